// File: rtl/input_conditioner_pkg.sv
// Shared types and constants for the input conditioner.
package input_conditioner_pkg;

  // Width of the accepted-press counter.
  localparam int unsigned PressCntW = 8;

  // Button interrupt FSM states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StHold    = 2'd2
  } irq_state_e;

endpackage

// File: rtl/input_debounce.sv
// Single-channel conditioner: 2-flop synchronizer, stability counter, stable register.
module input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_d, stable_q;
  logic [CntW-1:0] cnt_d, cnt_q;

  // Count consecutive cycles the synchronized input disagrees with the stable level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Synchronizer, counter and stable level registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  // Flags the edge on which stable_q will go 0->1; driven only from flops.
  assign rise_o   = stable_d & ~stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces a pushbutton and a switch bank; raises an interrupt per accepted press.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SW_WIDTH        = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 btn_i,
  input  logic [SW_WIDTH-1:0]  sw_i,
  output logic                 btn_db_o,
  output logic [SW_WIDTH-1:0]  sw_db_o,
  output logic                 irq_o,
  input  logic                 irq_ack_i,
  output logic                 overrun_o,
  output logic [PressCntW-1:0] press_cnt_o
);

  logic                 btn_rise;
  logic [SW_WIDTH-1:0]  sw_rise_unused;

  irq_state_e           state_d, state_q;
  logic                 irq_d, irq_q;
  logic                 overrun_d, overrun_q;
  logic [PressCntW-1:0] press_cnt_d, press_cnt_q;

  input_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .raw_i   (btn_i),
    .stable_o(btn_db_o),
    .rise_o  (btn_rise)
  );

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_db (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .raw_i   (sw_i[i]),
      .stable_o(sw_db_o[i]),
      .rise_o  (sw_rise_unused[i])
    );
  end

  // Next-state, overrun and press-count logic; rise is seen on the same edge btn_db_o rises.
  always_comb begin
    state_d     = state_q;
    overrun_d   = overrun_q;
    press_cnt_d = press_cnt_q + PressCntW'(btn_rise);
    unique case (state_q)
      StIdle: begin
        if (btn_rise) state_d = StPending;
      end
      StPending: begin
        if (btn_rise) begin
          // A new press with an ack replaces the old one; without an ack it is lost.
          overrun_d = ~irq_ack_i;
        end else if (irq_ack_i) begin
          overrun_d = 1'b0;
          state_d   = btn_db_o ? StHold : StIdle;
        end
      end
      StHold: begin
        if (btn_rise)       state_d = StPending;
        else if (!btn_db_o) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    irq_d = (state_d == StPending);
  end

  // FSM and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      overrun_q   <= overrun_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign irq_o       = irq_q;
  assign overrun_o   = overrun_q;
  assign press_cnt_o = press_cnt_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, SW_WIDTH=16.
module tb_input_conditioner;

  localparam int unsigned Db = 4;
  localparam int unsigned Sw = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          btn_i;
  logic [Sw-1:0] sw_i;
  logic          btn_db_o;
  logic [Sw-1:0] sw_db_o;
  logic          irq_o;
  logic          irq_ack_i;
  logic          overrun_o;
  logic [7:0]    press_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [Sw-1:0] sw;
    int unsigned   hold;
    logic [Sw-1:0] exp;
  } sw_vec_t;

  sw_vec_t vecs[11];

  input_conditioner #(
    .DEBOUNCE_CYCLES(Db),
    .SW_WIDTH       (Sw)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .btn_i      (btn_i),
    .sw_i       (sw_i),
    .btn_db_o   (btn_db_o),
    .sw_db_o    (sw_db_o),
    .irq_o      (irq_o),
    .irq_ack_i  (irq_ack_i),
    .overrun_o  (overrun_o),
    .press_cnt_o(press_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic ack_pulse();
    irq_ack_i = 1'b1;
    step(1);
    irq_ack_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h0008, 3, 16'h0000};  // 3-cycle glitch rejected
    vecs[1]  = '{16'h0000, 4, 16'h0000};
    vecs[2]  = '{16'hA5A5, 5, 16'h0000};  // one edge short
    vecs[3]  = '{16'hA5A5, 1, 16'hA5A5};  // accepted on edge 6
    vecs[4]  = '{16'h5A5A, 5, 16'hA5A5};
    vecs[5]  = '{16'h5A5A, 1, 16'h5A5A};
    vecs[6]  = '{16'h5A5B, 6, 16'h5A5B};
    vecs[7]  = '{16'hFFFF, 2, 16'h5A5B};
    vecs[8]  = '{16'hFFFF, 4, 16'hFFFF};
    vecs[9]  = '{16'hFFFE, 3, 16'hFFFF};  // low glitch rejected
    vecs[10] = '{16'hFFFF, 6, 16'hFFFF};

    rst_i = 1'b1; btn_i = 1'b0; sw_i = '0; irq_ack_i = 1'b0;
    step(2);
    rst_i = 1'b0;
    chk("rst btn_db", 32'(btn_db_o), 0);
    chk("rst sw_db", 32'(sw_db_o), 0);
    chk("rst irq", 32'(irq_o), 0);
    chk("rst overrun", 32'(overrun_o), 0);
    chk("rst press_cnt", 32'(press_cnt_o), 0);

    // Switch bank vectors
    for (int i = 0; i < 11; i++) begin
      sw_i = vecs[i].sw;
      step(int'(vecs[i].hold));
      chk($sformatf("sw vec %0d", i), 32'(sw_db_o), 32'(vecs[i].exp));
    end

    // Clean press: visible on the 6th edge, not the 5th
    btn_i = 1'b1;
    step(5);
    chk("press edge5 btn_db", 32'(btn_db_o), 0);
    chk("press edge5 irq", 32'(irq_o), 0);
    step(1);
    chk("press edge6 btn_db", 32'(btn_db_o), 1);
    chk("press edge6 irq", 32'(irq_o), 1);
    chk("press edge6 cnt", 32'(press_cnt_o), 1);
    chk("press edge6 overrun", 32'(overrun_o), 0);

    // Release and press again without ack -> overrun
    btn_i = 1'b0;
    step(6);
    chk("release btn_db", 32'(btn_db_o), 0);
    chk("release irq still", 32'(irq_o), 1);
    btn_i = 1'b1;
    step(6);
    chk("overrun cnt", 32'(press_cnt_o), 2);
    chk("overrun flag", 32'(overrun_o), 1);
    chk("overrun irq", 32'(irq_o), 1);

    // New press coincident with ack: stays pending, overrun clears, press counted
    btn_i = 1'b0;
    step(6);
    btn_i = 1'b1;
    step(5);
    chk("pre-coincident overrun", 32'(overrun_o), 1);
    irq_ack_i = 1'b1;
    step(1);
    irq_ack_i = 1'b0;
    chk("coincident irq", 32'(irq_o), 1);
    chk("coincident overrun", 32'(overrun_o), 0);
    chk("coincident cnt", 32'(press_cnt_o), 3);

    // Ack while held -> HOLD; second ack ignored
    ack_pulse();
    chk("hold irq", 32'(irq_o), 0);
    chk("hold overrun", 32'(overrun_o), 0);
    ack_pulse();
    chk("hold 2nd ack irq", 32'(irq_o), 0);
    chk("hold 2nd ack cnt", 32'(press_cnt_o), 3);
    btn_i = 1'b0;
    step(7);
    chk("hold release btn_db", 32'(btn_db_o), 0);
    ack_pulse();
    chk("idle ack ignored irq", 32'(irq_o), 0);

    // Press, release, then ack with button low -> IDLE
    btn_i = 1'b1;
    step(6);
    chk("press4 irq", 32'(irq_o), 1);
    chk("press4 cnt", 32'(press_cnt_o), 4);
    btn_i = 1'b0;
    step(6);
    chk("press4 released irq", 32'(irq_o), 1);
    ack_pulse();
    chk("ack to idle irq", 32'(irq_o), 0);
    btn_i = 1'b1;
    step(6);
    chk("press5 irq", 32'(irq_o), 1);
    chk("press5 cnt", 32'(press_cnt_o), 5);

    // One-cycle reset in PENDING with the button held
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    chk("midrst btn_db", 32'(btn_db_o), 0);
    chk("midrst sw_db", 32'(sw_db_o), 0);
    chk("midrst irq", 32'(irq_o), 0);
    chk("midrst overrun", 32'(overrun_o), 0);
    chk("midrst cnt", 32'(press_cnt_o), 0);
    step(5);
    chk("postrst edge5 irq", 32'(irq_o), 0);
    step(1);
    chk("postrst edge6 irq", 32'(irq_o), 1);
    chk("postrst edge6 cnt", 32'(press_cnt_o), 1);
    chk("postrst sw_db", 32'(sw_db_o), 32'hFFFF);

    // Wrap the press counter
    ack_pulse();
    btn_i = 1'b0;
    step(7);
    for (int i = 0; i < 255; i++) begin
      btn_i = 1'b1;
      step(6);
      if (i == 253) chk("wrap cnt 255", 32'(press_cnt_o), 255);
      ack_pulse();
      btn_i = 1'b0;
      step(7);
    end
    chk("wrap cnt 0", 32'(press_cnt_o), 0);
    chk("wrap irq idle", 32'(irq_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the number of consecutive stable cycles required to accept an input change; legal range 2..2^24.
REQ-002 The block SHALL have parameter SW_WIDTH, default 16, giving the switch-bank width.
REQ-003 Port clk_i SHALL be input, 1 bit: the single system clock.
REQ-004 Port rst_i SHALL be input, 1 bit: synchronous, active-high reset.
REQ-005 Port btn_i SHALL be input, 1 bit: raw asynchronous pushbutton.
REQ-006 Port sw_i SHALL be input, SW_WIDTH bits: raw asynchronous switches.
REQ-007 Port btn_db_o SHALL be output, 1 bit: debounced button level.
REQ-008 Port sw_db_o SHALL be output, SW_WIDTH bits: debounced switch levels.
REQ-009 Port irq_o SHALL be output, 1 bit: level interrupt request to the SoC (irq_btn_i).
REQ-010 Port irq_ack_i SHALL be input, 1 bit: single-cycle interrupt acknowledge.
REQ-011 Port overrun_o SHALL be output, 1 bit: sticky flag, press lost while an interrupt was pending.
REQ-012 Port press_cnt_o SHALL be output, 8 bits: count of accepted presses.

Function
REQ-013 Each of the 1+SW_WIDTH channels SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each channel SHALL hold a stable register and a counter of width $clog2(DEBOUNCE_CYCLES).
REQ-015 Synchronized value equal to stable -> counter SHALL clear to 0.
REQ-016 Synchronized value differs and counter < DEBOUNCE_CYCLES-1 -> counter SHALL increment.
REQ-017 Synchronized value differs and counter == DEBOUNCE_CYCLES-1 -> stable SHALL load the synchronized value and counter SHALL clear.
REQ-018 A clean input step SHALL appear on the debounced output exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the debounced output.
REQ-020 The IRQ FSM SHALL have states IDLE, PENDING and HOLD; irq_o SHALL be 1 only in PENDING.
REQ-021 IDLE -> PENDING SHALL occur on a debounced button rising edge (btn_db 0->1); press_cnt_o SHALL increment modulo 256 on every such edge regardless of state.
REQ-022 In PENDING with irq_ack_i=1 and no new rising edge: next state SHALL be HOLD if btn_db_o=1, else IDLE.
REQ-023 In PENDING with a rising edge and no ack: state SHALL remain PENDING and overrun_o SHALL set.
REQ-024 In PENDING with a rising edge and ack in the same cycle: state SHALL remain PENDING, overrun_o SHALL clear, and the press SHALL be counted.
REQ-025 In PENDING, irq_ack_i SHALL clear overrun_o.
REQ-026 HOLD -> IDLE SHALL occur when btn_db_o=0.
REQ-027 irq_ack_i in IDLE or HOLD SHALL be ignored.
REQ-028 All outputs SHALL be registered with no combinational path from inputs to outputs.

Reset
REQ-029 On rst_i=1 at a clock edge, synchronizers, stable registers, counters, btn_db_o, sw_db_o, irq_o, overrun_o and press_cnt_o SHALL become 0 and the FSM SHALL enter IDLE.
REQ-030 Reset asserted mid-debounce or in PENDING/HOLD SHALL abort the operation with no stored event.
REQ-031 A button held through reset release SHALL produce one press and one IRQ after DEBOUNCE_CYCLES+2 cycles.

Structure
REQ-032 A shared package input_conditioner_pkg SHALL define the FSM state enum (IDLE, PENDING, HOLD) and the press-counter width constant (8).
REQ-033 One sub-module, input_debounce (a single channel: synchronizer, counter, stable register), SHALL be instantiated 1+SW_WIDTH times.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-034 Hold btn_i=1 from cycle 10 -> btn_db_o=1 and irq_o=1 at cycle 16; press_cnt_o=1.
REQ-035 Pulse sw_i[3]=1 for 3 cycles -> sw_db_o stays 0x0000; hold sw_i=0xA5A5 -> sw_db_o=0xA5A5 after 6 cycles.
REQ-036 Press, release, press again without ack -> irq_o=1, overrun_o=1, press_cnt_o=2; ack -> overrun_o=0, irq_o=0.
REQ-037 Ack while the button is still held -> FSM in HOLD, irq_o=0; a second ack is ignored; release -> IDLE.
REQ-038 Assert rst_i for 1 cycle in PENDING with press_cnt_o=5 -> all outputs 0 next cycle; the held button re-raises irq_o 6 cycles after reset is released.
REQ-039 Run 256 presses -> press_cnt_o wraps to 0.
